// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
// UART_RX_PARITY_EN adds the PARITY state to the receiver FSM encoding.
package uart_pkg;
    localparam int UART_DATA_BITS        = 8;
    localparam int UART_CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, reset to RST_VAL.
// Latency: 2 system_clk cycles.
// Backpressure: none, free-running.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic system_clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), mid-bit sampling after a 2-flop sync.
// Latency: rx_valid rises on the edge after the stop-bit sample.
// Backpressure: single holding register; a byte completing while it is full is dropped with rx_overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic                      system_clk,
    input  logic                      reset_n,
    input  logic                      system_clk_locked,
    input  logic                      uart0_rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_frame_err,
    output logic                      rx_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      rx_parity_err
`endif
);
    localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(UART_DATA_BITS - 1);

    rx_state_e                 state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      rxd_s;
    logic                      expired;
    logic                      byte_done;
    logic                      frame_err;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q, par_bad_d;
    logic                      parity_err;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .system_clk (system_clk),
        .reset_n    (reset_n),
        .d          (uart0_rxd),
        .q          (rxd_s)
    );

    assign expired = (cnt_q == 16'd0);

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_err = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxd_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = FULL_RELOAD;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = FULL_RELOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    // Even parity: data bits plus parity bit must hold an even count of ones.
                    par_bad_d  = ^{shift_q, rxd_s};
                    parity_err = ^{shift_q, rxd_s};
                    cnt_d      = FULL_RELOAD;
                    state_d    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxd_s) begin
                    state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    byte_done = !par_bad_q;
`else
                    byte_done = 1'b1;
`endif
                end else begin
                    state_d   = ST_BREAK;
                    frame_err = 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxd_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing PLL lock abandons whatever frame was in flight.
        if (!system_clk_locked) begin
            state_d   = ST_IDLE;
            byte_done = 1'b0;
            frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err = 1'b0;
`endif
        end
    end

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= frame_err;
            rx_overrun   <= byte_done && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= parity_err;
`endif
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT = 16; define UART_RX_PARITY_EN to build the 8E1 variant.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       system_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       system_clk_locked = 1'b0;
    logic       uart0_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
    int         pecnt = 0;
`endif

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int fecnt = 0;
    int ovcnt = 0;
    int v0, f0, o0, lat;
`ifdef UART_RX_PARITY_EN
    int p0;
`endif

    always #5 system_clk = ~system_clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .system_clk        (system_clk),
        .reset_n           (reset_n),
        .system_clk_locked (system_clk_locked),
        .uart0_rxd         (uart0_rxd),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .rx_frame_err      (rx_frame_err),
        .rx_overrun        (rx_overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err     (rx_parity_err)
`endif
    );

    always @(negedge system_clk) begin
        if (rx_valid)     vcnt++;
        if (rx_frame_err) fecnt++;
        if (rx_overrun)   ovcnt++;
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err) pecnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge system_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        uart0_rxd = v;
        tick(CPB);
    endtask

    // par_flip inverts the correct even-parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_v);
        uart0_rxd = 1'b1;
        tick(2 * CPB);
    endtask

    initial begin
        reset_n = 1'b0;
        tick(3);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_frame_err", 32'(rx_frame_err), 32'd0);
        chk("reset_overrun", 32'(rx_overrun), 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset_n = 1'b1;
        system_clk_locked = 1'b1;
        tick(4);

        // Frame 0x55 with the consumer always ready, plus first-byte latency.
        rx_ready = 1'b1;
        v0 = vcnt; f0 = fecnt; o0 = ovcnt;
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                while (lat < 400) begin
                    @(negedge system_clk);
                    if (rx_valid) break;
                    lat++;
                end
            end
        join
        chk("lat_0x55", 32'(lat), 32'(LAT));
        chk("data_0x55", 32'(rx_data), 32'h55);
        chk("valid_cycles_0x55", 32'(vcnt - v0), 32'd1);
        chk("no_ferr_0x55", 32'(fecnt - f0), 32'd0);
        chk("no_ovr_0x55", 32'(ovcnt - o0), 32'd0);

        // Four-cycle glitch: START entered, then abandoned at the half-bit sample.
        v0 = vcnt;
        uart0_rxd = 1'b0;
        tick(4);
        uart0_rxd = 1'b1;
        chk("glitch_in_start", 32'(dut.state_q), 32'(ST_START));
        tick(8);
        chk("glitch_back_idle", 32'(dut.state_q), 32'(ST_IDLE));
        tick(2 * CPB);
        chk("glitch_no_valid", 32'(vcnt - v0), 32'd0);

        // Bad stop bit, then a clean frame once the line idles.
        v0 = vcnt; f0 = fecnt;
        send_frame(8'hA3, 1'b0, 1'b0);
        chk("ferr_pulse", 32'(fecnt - f0), 32'd1);
        chk("ferr_no_valid", 32'(vcnt - v0), 32'd0);
        chk("ferr_back_idle", 32'(dut.state_q), 32'(ST_IDLE));
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("data_0x3c", 32'(rx_data), 32'h3C);
        chk("valid_cycles_0x3c", 32'(vcnt - v0), 32'd1);

        // Overrun: second byte dropped while the first is held.
        rx_ready = 1'b0;
        o0 = ovcnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("ovr_pulse", 32'(ovcnt - o0), 32'd1);
        chk("ovr_held_data", 32'(rx_data), 32'h11);
        chk("ovr_held_valid", 32'(rx_valid), 32'd1);

        // Handshake on the exact completion cycle replaces the held byte without overrun.
        fork
            send_frame(8'h5A, 1'b1, 1'b0);
            begin
                tick(LAT - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        chk("same_cycle_data", 32'(rx_data), 32'h5A);
        chk("same_cycle_valid", 32'(rx_valid), 32'd1);
        chk("same_cycle_no_ovr", 32'(ovcnt - o0), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        chk("handshake_clears", 32'(rx_valid), 32'd0);

        // Lock lost during bit 4 of 0xFF.
        v0 = vcnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        system_clk_locked = 1'b0;
        tick(2);
        chk("unlock_idle", 32'(dut.state_q), 32'(ST_IDLE));
        tick(CPB);
        system_clk_locked = 1'b1;
        tick(6 * CPB);
        chk("unlock_no_valid", 32'(vcnt - v0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        chk("relock_data", 32'(rx_data), 32'h81);
        chk("relock_valid_cycles", 32'(vcnt - v0), 32'd1);

        // Reset in the middle of a frame.
        drive_bit(1'b0);
        drive_bit(1'b0);
        uart0_rxd = 1'b1;
        reset_n = 1'b0;
        tick(2);
        chk("midreset_data", 32'(rx_data), 32'h00);
        reset_n = 1'b1;
        tick(4);
        chk("midreset_idle", 32'(dut.state_q), 32'(ST_IDLE));
        send_frame(8'hC5, 1'b1, 1'b0);
        chk("after_reset_data", 32'(rx_data), 32'hC5);

`ifdef UART_RX_PARITY_EN
        v0 = vcnt; p0 = pecnt;
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_err_pulse", 32'(pecnt - p0), 32'd1);
        chk("par_err_no_valid", 32'(vcnt - v0), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_ok_data", 32'(rx_data), 32'h07);
        chk("par_ok_valid", 32'(vcnt - v0), 32'd1);
        chk("par_ok_no_err", 32'(pecnt - p0), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, the system_clk cycles per bit (100 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have port system_clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port system_clk_locked  input  1  PLL lock; receiver idles while low.
REQ-005 SHALL have port uart0_rxd  input  1  asynchronous serial line, idle high, 8N1 (8E1 with macro).
REQ-006 SHALL have port rx_data  output  8  received byte, LSB = first data bit.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
REQ-009 SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port rx_overrun  output  1  one-cycle pulse: byte completed while holding register full.

Function
REQ-011 uart0_rxd SHALL pass through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-013 IDLE -> START when synced rxd = 0 and system_clk_locked = 1; bit counter loads CLKS_PER_BIT/2 - 1 (integer division).
REQ-014 START: on counter expiry, sample; 1 -> IDLE (glitch, no output); 0 -> DATA with counter reloaded to CLKS_PER_BIT - 1.
REQ-015 DATA: sample once per counter expiry, shift in LSB first; after the 8th sample -> PARITY if enabled, else STOP.
REQ-016 STOP: on expiry sample; 1 -> byte complete, IDLE; 0 -> rx_frame_err pulse, byte discarded, BREAK.
REQ-017 BREAK: remain until synced rxd = 1, then IDLE; no new start is detected in BREAK.
REQ-018 Byte completion SHALL load rx_data and set rx_valid on the next clock edge after the stop-bit sample cycle.
REQ-019 rx_valid SHALL stay 1 and rx_data stable until a cycle with rx_ready = 1; then rx_valid clears next edge.
REQ-020 Completion while rx_valid = 1 and rx_ready = 0: rx_overrun pulse, new byte dropped, held byte kept.
REQ-021 Completion in the same cycle as a handshake: new byte loaded, rx_valid remains 1, no overrun.
REQ-022 system_clk_locked = 0 SHALL force IDLE on the next edge, discarding any partial frame; holding register and rx_valid unaffected.
REQ-023 rx_ready while rx_valid = 0 SHALL have no effect.

Reset
REQ-024 reset_n low SHALL asynchronously set: FSM IDLE, counters 0, shift register 0, rx_data 8'h00, rx_valid 0, rx_frame_err 0, rx_overrun 0, parity error 0, synchronizer flops 1.
REQ-025 Deassertion mid-frame SHALL resume in IDLE, waiting for a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after data; mismatch pulses output rx_parity_err (1 bit) for one cycle and drops the byte; stop handling unchanged.
REQ-027 Macro undefined: no PARITY state, no rx_parity_err port, frame is 8N1.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state enum, UART_DATA_BITS = 8 and the default CLKS_PER_BIT constant.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (1-bit, parameterised reset value), instantiated once.

Verification (CLKS_PER_BIT = 16)
REQ-030 Frame 0x55, rx_ready = 1 -> rx_data = 8'h55, rx_valid high exactly 1 cycle, no error pulses.
REQ-031 Line low for 4 cycles then high -> no rx_valid, FSM back in IDLE by cycle 10.
REQ-032 Frame 0xA3 with stop bit 0 -> rx_frame_err one pulse, rx_valid stays 0, next frame 0x3C received correctly after line returns high.
REQ-033 Frames 0x11 then 0x22, rx_ready = 0 -> rx_overrun one pulse, rx_data = 8'h11 held; after rx_ready, rx_valid clears.
REQ-034 system_clk_locked dropped during bit 4 of 0xFF -> no rx_valid; frame 0x81 sent after relock received as 8'h81.
REQ-035 With UART_RX_PARITY_EN, 0x07 sent with parity bit 0 -> rx_parity_err pulse, no rx_valid; with parity 1 -> rx_data = 8'h07.
